hazard_bypass_ctrl: RTL and testbench

//  Hazard and forwarding controller between DECODE and EXECUTE. Tracks destination registers of
//  the instructions in EX, MEM and WB. Generates the registered bypass selects that the EXECUTE

---
 rtl/hazard_bypass_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_bypass_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_bypass_ctrl.sv
// hazard_bypass_ctrl
//   Hazard and forwarding controller sitting between DECODE and EXECUTE.
//   Tracks the destination register of the instructions in EX, MEM and WB,
//   produces registered operand bypass selects for the EX stage
//   (0 = register file data, 1 = MEM-stage data, 2 = WB-stage data) and
//   detects load-use hazards, stalling DECODE for one cycle while a bubble
//   is pushed into EX.
//
// Parameters
//   REG_ADDR_W  register address width
//   CNT_W       stall counter width
//
// Ports
//   CLK           in   clock, rising edge
//   RST_N         in   asynchronous active-low reset
//   ID_VALID      in   DECODE holds a valid instruction
//   ID_RS/ID_RT   in   source registers of the DECODE instruction
//   ID_USES_RS/RT in   the instruction reads RS / RT
//   ID_RD         in   destination register
//   ID_REG_WRITE  in   instruction writes ID_RD
//   ID_MEM_READ   in   instruction is a load
//   FLUSH         in   squash the EX and DECODE instructions (taken branch)
//   STALL         out  hold PC and IF/ID (combinational)
//   EX_VALID      out  EX holds a real (non-bubble) instruction
//   BYPASS_SEL_A  out  operand A bypass select for the EX instruction
//   BYPASS_SEL_B  out  operand B bypass select for the EX instruction
//   STALL_COUNT   out  stall cycles since reset
//
// Configuration
//   STALL_COUNTER_EN  when defined, STALL_COUNT counts stall cycles and
//                     saturates at all-ones; otherwise it is tied to zero
//                     and no counter flops exist.

module hazard_bypass_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS,
  input  logic [REG_ADDR_W-1:0] ID_RT,
  input  logic                  ID_USES_RS,
  input  logic                  ID_USES_RT,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  input  logic                  FLUSH,
  output logic                  STALL,
  output logic                  EX_VALID,
  output logic [1:0]            BYPASS_SEL_A,
  output logic [1:0]            BYPASS_SEL_B,
  output logic [CNT_W-1:0]      STALL_COUNT
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } entry_t;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  entry_t     r_ex;
  entry_t     r_mem;
  entry_t     r_wb;
  logic [1:0] r_sel_a;
  logic [1:0] r_sel_b;

  entry_t     w_id_entry;
  logic       w_load_ex;
  logic       w_stall;
  logic [1:0] w_sel_a_nxt;
  logic [1:0] w_sel_b_nxt;

  // An entry produces register r only when it really writes it; r0 is
  // hard-wired and never forwarded.
  function automatic logic f_writes(input entry_t e,
                                    input logic [REG_ADDR_W-1:0] r);
    return e.valid & e.reg_write & (e.rd == r) & (r != '0);
  endfunction

  // Forwarding source for one operand, judged before the pipeline shifts:
  // the EX producer will be in MEM, the MEM producer in WB. The younger
  // (EX) producer has priority.
  function automatic logic [1:0] f_sel(input logic                  uses,
                                       input logic [REG_ADDR_W-1:0] r,
                                       input entry_t                ex,
                                       input entry_t                mem);
    logic [1:0] sel;
    sel = SEL_REG;
    if (uses) begin
      if (f_writes(ex, r))       sel = SEL_MEM;
      else if (f_writes(mem, r)) sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    w_id_entry.valid     = 1'b1;
    w_id_entry.rd        = ID_RD;
    w_id_entry.reg_write = ID_REG_WRITE;
    w_id_entry.mem_read  = ID_MEM_READ;
  end

  // Load-use: a load in EX has no data until it reaches WB, so a consumer
  // in DECODE waits one cycle. FLUSH overrides since DECODE is squashed.
  always_comb begin
    w_stall = 1'b0;
    if (ID_VALID && !FLUSH && r_ex.mem_read &&
        ((ID_USES_RS && f_writes(r_ex, ID_RS)) ||
         (ID_USES_RT && f_writes(r_ex, ID_RT))))
      w_stall = 1'b1;
  end

  assign w_load_ex = ID_VALID & ~w_stall & ~FLUSH;

  // A bubble entering EX carries select 0 on both operands.
  always_comb begin
    w_sel_a_nxt = SEL_REG;
    w_sel_b_nxt = SEL_REG;
    if (w_load_ex) begin
      w_sel_a_nxt = f_sel(ID_USES_RS, ID_RS, r_ex, r_mem);
      w_sel_b_nxt = f_sel(ID_USES_RT, ID_RT, r_ex, r_mem);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
    end else begin
      r_wb    <= r_mem;
      r_mem   <= FLUSH ? '0 : r_ex;
      r_ex    <= w_load_ex ? w_id_entry : '0;
      r_sel_a <= w_sel_a_nxt;
      r_sel_b <= w_sel_b_nxt;
    end
  end

  // The WB entry and the MEM load flag are tracked for completeness of the
  // pipeline picture; WB-to-DECODE hazards are absorbed by the write-first
  // register file, so nothing consumes them.
  logic w_unused_track;
  assign w_unused_track = ^{r_wb, r_mem.mem_read};

  assign STALL        = w_stall;
  assign EX_VALID     = r_ex.valid;
  assign BYPASS_SEL_A = r_sel_a;
  assign BYPASS_SEL_B = r_sel_b;

`ifdef STALL_COUNTER_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
  end

  assign STALL_COUNT = r_stall_cnt;
`else
  assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_hazard_bypass_ctrl.sv
module tb_hazard_bypass_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        ID_VALID;
  logic [4:0]  ID_RS;
  logic [4:0]  ID_RT;
  logic        ID_USES_RS;
  logic        ID_USES_RT;
  logic [4:0]  ID_RD;
  logic        ID_REG_WRITE;
  logic        ID_MEM_READ;
  logic        FLUSH;
  logic        STALL;
  logic        EX_VALID;
  logic [1:0]  BYPASS_SEL_A;
  logic [1:0]  BYPASS_SEL_B;
  logic [31:0] STALL_COUNT;

  hazard_bypass_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ID_VALID     (ID_VALID),
    .ID_RS        (ID_RS),
    .ID_RT        (ID_RT),
    .ID_USES_RS   (ID_USES_RS),
    .ID_USES_RT   (ID_USES_RT),
    .ID_RD        (ID_RD),
    .ID_REG_WRITE (ID_REG_WRITE),
    .ID_MEM_READ  (ID_MEM_READ),
    .FLUSH        (FLUSH),
    .STALL        (STALL),
    .EX_VALID     (EX_VALID),
    .BYPASS_SEL_A (BYPASS_SEL_A),
    .BYPASS_SEL_B (BYPASS_SEL_B),
    .STALL_COUNT  (STALL_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the in-flight instructions listed by age
  // (0 = in EX, 1 = in MEM, 2 = in WB).
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } instr_t;

  instr_t      pipe[3];
  bit          m_stall;
  int          m_sel_a;
  int          m_sel_b;
  logic [31:0] m_cnt;

  function automatic bit produces(input instr_t e, input int r);
    return e.v && e.rw && (e.rd == r) && (r != 0);
  endfunction

  // Youngest in-flight producer of r wins; its age after the shift is the select.
  function automatic int source_of(input bit used, input int r);
    if (!used) return 0;
    for (int age = 0; age < 2; age++)
      if (produces(pipe[age], r)) return age + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_sel_a = 0;
    m_sel_b = 0;
    m_cnt   = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive DECODE, check the combinational stall, advance the
  // model, then check the registered outputs just after the edge.
  task automatic cyc(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                     input int rd, input bit rw, input bit mr, input bit fl);
    bit load;
    ID_VALID     = v;
    ID_RS        = 5'(rs);
    ID_RT        = 5'(rt);
    ID_USES_RS   = urs;
    ID_USES_RT   = urt;
    ID_RD        = 5'(rd);
    ID_REG_WRITE = rw;
    ID_MEM_READ  = mr;
    FLUSH        = fl;
    #1;
    m_stall = v && !fl && pipe[0].v && pipe[0].mr &&
              ((urs && produces(pipe[0], rs)) || (urt && produces(pipe[0], rt)));
    chk("stall", {31'd0, STALL}, {31'd0, m_stall});
    load = v && !m_stall && !fl;
    m_sel_a = load ? source_of(urs, rs) : 0;
    m_sel_b = load ? source_of(urt, rt) : 0;
`ifdef STALL_COUNTER_EN
    if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    pipe[2] = pipe[1];
    pipe[1] = fl ? '{0, 0, 0, 0} : pipe[0];
    pipe[0] = load ? '{1, rd, rw, mr} : '{0, 0, 0, 0};
    @(posedge CLK);
    #1;
    chk("ex_valid", {31'd0, EX_VALID}, {31'd0, pipe[0].v});
    chk("sel_a", {30'd0, BYPASS_SEL_A}, 32'(m_sel_a));
    chk("sel_b", {30'd0, BYPASS_SEL_B}, 32'(m_sel_b));
    chk("stall_count", STALL_COUNT, m_cnt);
    @(negedge CLK);
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, STALL}, 32'd0);
    chk({tag, "_ex_valid"}, {31'd0, EX_VALID}, 32'd0);
    chk({tag, "_sel_a"}, {30'd0, BYPASS_SEL_A}, 32'd0);
    chk({tag, "_sel_b"}, {30'd0, BYPASS_SEL_B}, 32'd0);
    chk({tag, "_count"}, STALL_COUNT, 32'd0);
  endtask

  logic [31:0] cnt_before;

  initial begin
    RST_N = 1'b0;
    ID_VALID = 0; ID_RS = 0; ID_RT = 0; ID_USES_RS = 0; ID_USES_RT = 0;
    ID_RD = 0; ID_REG_WRITE = 0; ID_MEM_READ = 0; FLUSH = 0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    // 1: add r3,r1,r2 ; add r4,r3,r3 -> both operands from MEM, no stall
    cyc(1, 1, 2, 1, 1, 3, 1, 0, 0);
    cyc(1, 3, 3, 1, 1, 4, 1, 0, 0);
    chk("t1_stall", {31'd0, m_stall}, {31'd0, STALL}); // stall seen during consumer
    chk("t1_sel_a", {30'd0, BYPASS_SEL_A}, 32'd1);
    chk("t1_sel_b", {30'd0, BYPASS_SEL_B}, 32'd1);
    drain();

    // 2: add r3 ; nop ; sub r5,r3,r6 -> A from WB, B from register file
    cyc(1, 1, 2, 1, 1, 3, 1, 0, 0);
    nop();
    cyc(1, 3, 6, 1, 1, 5, 1, 0, 0);
    chk("t2_sel_a", {30'd0, BYPASS_SEL_A}, 32'd2);
    chk("t2_sel_b", {30'd0, BYPASS_SEL_B}, 32'd0);
    drain();

    // 3: add r3 ; add r3 ; or r7,r3,r3 -> younger producer wins
    cyc(1, 1, 2, 1, 1, 3, 1, 0, 0);
    cyc(1, 4, 5, 1, 1, 3, 1, 0, 0);
    cyc(1, 3, 3, 1, 1, 7, 1, 0, 0);
    chk("t3_sel_a", {30'd0, BYPASS_SEL_A}, 32'd1);
    chk("t3_sel_b", {30'd0, BYPASS_SEL_B}, 32'd1);
    drain();

    // 4: lw r8 ; add r9,r8,r1 -> one stall cycle, bubble, then A from WB
    cnt_before = m_cnt;
    cyc(1, 2, 0, 1, 0, 8, 1, 1, 0);
    cyc(1, 8, 1, 1, 1, 9, 1, 0, 0);
    chk("t4_stall_hi", {31'd0, m_stall}, 32'd1);
    chk("t4_bubble", {31'd0, EX_VALID}, 32'd0);
    cyc(1, 8, 1, 1, 1, 9, 1, 0, 0);
    chk("t4_stall_lo", {31'd0, STALL}, 32'd0);
    chk("t4_ex_valid", {31'd0, EX_VALID}, 32'd1);
    chk("t4_sel_a", {30'd0, BYPASS_SEL_A}, 32'd2);
    chk("t4_sel_b", {30'd0, BYPASS_SEL_B}, 32'd0);
`ifdef STALL_COUNTER_EN
    chk("t4_count", STALL_COUNT, cnt_before + 32'd1);
`else
    chk("t4_count", STALL_COUNT, 32'd0);
`endif
    drain();

    // 5: add r0 ; add r1,r0,r0 -> r0 never forwarded
    cyc(1, 1, 2, 1, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 1, 1, 0, 0);
    chk("t5_sel_a", {30'd0, BYPASS_SEL_A}, 32'd0);
    chk("t5_sel_b", {30'd0, BYPASS_SEL_B}, 32'd0);
    drain();

    // 6: lw r8 in EX, consumer in ID with FLUSH -> no stall, bubble, load squashed
    cyc(1, 2, 0, 1, 0, 8, 1, 1, 0);
    cyc(1, 8, 8, 1, 1, 9, 1, 0, 1);
    chk("t6_stall", {31'd0, m_stall}, 32'd0);
    chk("t6_bubble", {31'd0, EX_VALID}, 32'd0);
    cyc(1, 8, 8, 1, 1, 9, 1, 0, 0);
    chk("t6_no_fwd_a", {30'd0, BYPASS_SEL_A}, 32'd0);
    chk("t6_no_fwd_b", {30'd0, BYPASS_SEL_B}, 32'd0);

    // Async reset in the middle of a load-use stall
    cyc(1, 2, 0, 1, 0, 8, 1, 1, 0);
    ID_VALID = 1; ID_RS = 5'd8; ID_USES_RS = 1; ID_RD = 5'd9; ID_REG_WRITE = 1;
    ID_MEM_READ = 0; FLUSH = 0;
    #1;
    chk("mid_stall_hi", {31'd0, STALL}, 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    model_reset();
    chk_all_zero("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    drain();

    // Randomized traffic against the model, with one more reset in between
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        chk_all_zero("rand_rst");
        @(negedge CLK);
        RST_N = 1'b1;
      end
      cyc(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 8),
          $urandom % 2, $urandom % 2, int'($urandom % 8),
          ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=not finished expected=finished");
    $fatal(1, "timeout");
  end

endmodule
